axil_sram_slave: RTL and testbench
==================================

Name: axil_sram_slave

Overview:
- Data-side memory model: an AXI4-Lite slave that terminates the EXU load/store channels (AW, W, B, AR, R) with a byte-strobed word SRAM.
- Read and write channels have independent state machines, each with a programmable response latency, to exercise EXU handshake stalls.
- Instantiated at top level next to the EXU; replaces the zero-latency data memory.

Parameters:
- DATA_WIDTH, 32, data and address width.
- DEPTH, 4096, number of 32-bit words.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 2, extra wait cycles between AR handshake and rvalid (0..15).
- WR_LAT, 2, extra wait cycles between capture of both AW and W and bvalid (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dsram_awaddr  in  32  write byte address
- dsram_awvalid  in  1  write address valid
- dsram_awready  out  1  write address accepted
- dsram_wdata  in  32  write data
- dsram_wstrb  in  4  byte-lane enables; bit i selects wdata[8i+7:8i]
- dsram_wvalid  in  1  write data valid
- dsram_wready  out  1  write data accepted
- dsram_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- dsram_bvalid  out  1  write response valid
- dsram_bready  in  1  master accepts B
- dsram_araddr  in  32  read byte address
- dsram_arvalid  in  1  read address valid
- dsram_arready  out  1  read address accepted
- dsram_rdata  out  32  read data
- dsram_rresp  out  2  read response
- dsram_rvalid  out  1  read data valid
- dsram_rready  in  1  master accepts R

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: while rst=1, all outputs are 0 and both FSMs go to IDLE. The memory array is not reset.
- Reset mid-transaction: the transaction is dropped. A write not yet committed is not committed.
- Address decode: idx = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
  - In range when addr >= BASE_ADDR and idx < DEPTH.
  - Otherwise resp = 2'b10, rdata = 0, and no write occurs.

Read FSM (R_IDLE, R_WAIT, R_RESP):
- R_IDLE:
  - arready = 1.
  - On arvalid, latch araddr and load cnt = RD_LAT.
  - Go to R_WAIT, or to R_RESP if RD_LAT = 0.
- R_WAIT:
  - arready = 0; cnt decrements each cycle.
  - When cnt = 1, go to R_RESP; on that transition, register rdata = mem[idx] and rresp.
- R_RESP:
  - rvalid = 1; rdata and rresp stay stable until rready.
  - On rvalid & rready, return to R_IDLE; rvalid drops the next cycle.
- Latency: rvalid rises RD_LAT+1 cycles after the AR handshake.
- Throughput: at most one outstanding read; the next arready comes the cycle after the R handshake.

Write FSM (W_IDLE, W_WAIT, W_RESP):
- W_IDLE:
  - awready = 1 until AW is captured; wready = 1 until W is captured.
  - AW and W are captured independently, in either order or in the same cycle.
  - Once both are held, load cnt = WR_LAT and go to W_WAIT (or W_RESP if WR_LAT = 0).
- W_WAIT: counts down as in the read FSM.
- Commit: on the transition into W_RESP, write the enabled bytes of mem[idx] (only if in range).
- W_RESP:
  - bvalid = 1 with bresp held until bready, then return to W_IDLE.
  - awready and wready stay 0 outside W_IDLE.
- wstrb = 0: the write is OKAY and no bytes change.

Read/write interaction:
- If a read samples the same word in the cycle the write commits, the read returns the old data (read-before-write).
- A read sampled in any later cycle sees the new data.
- The two FSMs never stall each other.

Decomposition:
- Package axil_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - read and write state encodings (2-bit localparams);
  - the latency counter width (4).
- Sub-module axil_sram_array: DEPTH x 32 storage, one synchronous byte-strobed write port and one synchronous read port, read-before-write. Decode and both FSMs stay in the top block.

Test Plan:
- Reset: hold rst 3 cycles, release -> all outputs 0 during reset; arready = awready = wready = 1 on the first post-reset cycle.
- Write then read, RD_LAT = WR_LAT = 2:
  - Send AW 0x8000_0010 and W 0xDEAD_BEEF (wstrb 4'hF) in the same cycle -> bvalid 3 cycles later with bresp 00.
  - Then AR 0x8000_0010 -> rvalid 3 cycles after the AR handshake with rdata 0xDEAD_BEEF.
- Byte strobes and ordering:
  - Word holds 0x1122_3344. Send W 0xAABB_CCDD with wstrb 4'b0101, with W two cycles before AW.
  - Read -> 0x11BB_33DD.
  - bvalid is held while bready is low for 4 cycles; bvalid stays 1 and bresp stays stable throughout.
- Out of range:
  - AR 0x7FFF_FFFC -> rresp 10, rdata 0.
  - Write to BASE_ADDR + 4*DEPTH -> bresp 10; a readback of word DEPTH-1 is unchanged.
- Concurrency: a write committing to word 5 in the same cycle a read samples word 5 -> the read returns the old value; the next read returns the new value.
- Reset mid-write: after AW and W are captured, assert rst during W_WAIT -> bvalid never rises and the target word is unchanged.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared response codes, FSM state encodings and counter width for the
// AXI4-Lite data-side SRAM slave.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam int CNT_W = 4;

endpackage

// File: rtl/axil_sram_array.sv
// DEPTH-word SRAM with one byte-strobed synchronous write port and one
// registered read port; a same-cycle read of the written word sees old data.
module axil_sram_array #(
    parameter int  DEPTH      = 4096,
    parameter int  DATA_WIDTH = 32,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int NB         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [NB-1:0]         wstrb_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    // One independent byte-wide memory per lane keeps each lane a plain
    // single-write-port RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (we_i && wstrb_i[gi]) begin
                    mem[waddr_i] <= wdata_i[8*gi +: 8];
                end
                if (re_i) begin
                    rd_q <= mem[raddr_i];
                end
            end

            assign rdata_o[8*gi +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave over a byte-strobed word SRAM with independent read and
// write FSMs, each adding a programmable response latency.
module axil_sram_slave
    import axil_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  DEPTH      = 4096,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                  RD_LAT     = 2,
    parameter int                  WR_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   dsram_awaddr,
    input  logic                    dsram_awvalid,
    output logic                    dsram_awready,
    input  logic [DATA_WIDTH-1:0]   dsram_wdata,
    input  logic [DATA_WIDTH/8-1:0] dsram_wstrb,
    input  logic                    dsram_wvalid,
    output logic                    dsram_wready,
    output logic [1:0]              dsram_bresp,
    output logic                    dsram_bvalid,
    input  logic                    dsram_bready,
    input  logic [DATA_WIDTH-1:0]   dsram_araddr,
    input  logic                    dsram_arvalid,
    output logic                    dsram_arready,
    output logic [DATA_WIDTH-1:0]   dsram_rdata,
    output logic [1:0]              dsram_rresp,
    output logic                    dsram_rvalid,
    input  logic                    dsram_rready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_WIDTH / 8;

    function automatic logic in_range(input logic [DATA_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] word_off;
        word_off = (addr - BASE_ADDR) >> 2;
        return (addr >= BASE_ADDR) && (word_off < DATA_WIDTH'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [DATA_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [1:0]            rd_state_q, rd_state_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rd_sample;
    logic [DATA_WIDTH-1:0] rd_addr_eff;

    logic [1:0]            wr_state_q, wr_state_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  wr_commit;
    logic                  aw_fire, w_fire;
    logic [DATA_WIDTH-1:0] wr_addr_eff, wr_data_eff;
    logic [NB-1:0]         wr_strb_eff;

    logic [DATA_WIDTH-1:0] ram_rdata;

    // Outputs are forced low while reset is held, whatever the state.
    assign dsram_arready = !rst && (rd_state_q == R_IDLE);
    assign dsram_rvalid  = !rst && (rd_state_q == R_RESP);
    assign dsram_rresp   = dsram_rvalid ? rresp_q : RESP_OKAY;
    assign dsram_rdata   = (dsram_rvalid && rresp_q == RESP_OKAY) ? ram_rdata : '0;

    assign dsram_awready = !rst && (wr_state_q == W_IDLE) && !aw_held_q;
    assign dsram_wready  = !rst && (wr_state_q == W_IDLE) && !w_held_q;
    assign dsram_bvalid  = !rst && (wr_state_q == W_RESP);
    assign dsram_bresp   = dsram_bvalid ? bresp_q : RESP_OKAY;

    // With zero latency the sample happens in the AR handshake cycle itself.
    assign rd_addr_eff = (rd_state_q == R_IDLE) ? dsram_araddr : araddr_q;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        araddr_d   = araddr_q;
        rresp_d    = rresp_q;
        rd_sample  = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (dsram_arvalid) begin
                    araddr_d = dsram_araddr;
                    rd_cnt_d = CNT_W'(RD_LAT);
                    if (RD_LAT == 0) begin
                        rd_state_d = R_RESP;
                        rd_sample  = 1'b1;
                    end else begin
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                rd_cnt_d = rd_cnt_q - CNT_W'(1);
                if (rd_cnt_q == CNT_W'(1)) begin
                    rd_state_d = R_RESP;
                    rd_sample  = 1'b1;
                end
            end
            R_RESP: begin
                if (dsram_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        if (rd_sample) begin
            rresp_d = in_range(rd_addr_eff) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            araddr_q   <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            araddr_q   <= araddr_d;
            rresp_q    <= rresp_d;
        end
    end

    assign aw_fire = dsram_awready && dsram_awvalid;
    assign w_fire  = dsram_wready && dsram_wvalid;

    // Held halves come from the capture registers, fresh ones straight from the bus.
    assign wr_addr_eff = aw_held_q ? awaddr_q : dsram_awaddr;
    assign wr_data_eff = w_held_q ? wdata_q : dsram_wdata;
    assign wr_strb_eff = w_held_q ? wstrb_q : dsram_wstrb;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = dsram_awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = dsram_wdata;
                    wstrb_d  = dsram_wstrb;
                end
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    wr_cnt_d = CNT_W'(WR_LAT);
                    if (WR_LAT == 0) begin
                        wr_state_d = W_RESP;
                        wr_commit  = 1'b1;
                    end else begin
                        wr_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                wr_cnt_d = wr_cnt_q - CNT_W'(1);
                if (wr_cnt_q == CNT_W'(1)) begin
                    wr_state_d = W_RESP;
                    wr_commit  = 1'b1;
                end
            end
            W_RESP: begin
                if (dsram_bready) begin
                    wr_state_d = W_IDLE;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (wr_commit) begin
            bresp_d = in_range(wr_addr_eff) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    axil_sram_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_commit && !rst && in_range(wr_addr_eff)),
        .waddr_i (to_idx(wr_addr_eff)),
        .wdata_i (wr_data_eff),
        .wstrb_i (wr_strb_eff),
        .re_i    (rd_sample && !rst),
        .raddr_i (to_idx(rd_addr_eff)),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed bench for axil_sram_slave: handshakes, latency, strobes, decode
// errors, read-before-write and reset during a pending write.
module tb_axil_sram_slave;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;

    axil_sram_slave #(
        .DATA_WIDTH (32),
        .DEPTH      (4096),
        .BASE_ADDR  (32'h8000_0000),
        .RD_LAT     (2),
        .WR_LAT     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dsram_awaddr  (awaddr),
        .dsram_awvalid (awvalid),
        .dsram_awready (awready),
        .dsram_wdata   (wdata),
        .dsram_wstrb   (wstrb),
        .dsram_wvalid  (wvalid),
        .dsram_wready  (wready),
        .dsram_bresp   (bresp),
        .dsram_bvalid  (bvalid),
        .dsram_bready  (bready),
        .dsram_araddr  (araddr),
        .dsram_arvalid (arvalid),
        .dsram_arready (arready),
        .dsram_rdata   (rdata),
        .dsram_rresp   (rresp),
        .dsram_rvalid  (rvalid),
        .dsram_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int k;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b0;
        k = 0;
        while (!arready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val("ar_accept", 32'(k < 20), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        $display("read  addr=0x%08h data=0x%08h resp=%0d lat=%0d", addr, data, resp, lat);
    endtask

    // W is presented w_lead cycles before AW; B is left unaccepted for bhold cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int bhold,
                            output logic [1:0] resp, output int lat);
        bit aw_done, w_done, hs_aw, hs_w;
        aw_done = 1'b0;
        w_done  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 30 && !(aw_done && w_done); k++) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (k >= w_lead);
            wvalid  = !w_done;
            hs_aw   = awvalid && awready;
            hs_w    = wvalid && wready;
            @(negedge clk);
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_val("aw_w_accept", 32'({aw_done, w_done}), 32'd3);
        lat = 1;
        while (!bvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        resp = bresp;
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            check_val("b_hold_valid", 32'(bvalid), 32'd1);
            check_val("b_hold_resp", 32'(bresp), 32'(resp));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        $display("write addr=0x%08h data=0x%08h strb=0x%h resp=%0d lat=%0d", addr, data, strb, resp, lat);
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bit          seen_b;

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset: every output low for three cycles, then all channels ready.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_outs", {arready, awready, wready, bvalid, rvalid, bresp, rresp, 23'd0} | rdata, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", 32'({arready, awready, wready, bvalid, rvalid}), 32'b11100);
        $display("reset released");

        // Same-cycle AW and W, then read back.
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, r, lat);
        check_val("wr1_resp", 32'(r), 32'd0);
        check_val("wr1_lat", 32'(lat), 32'd3);
        do_read(32'h8000_0010, d, r, lat);
        check_val("rd1_data", d, 32'hDEAD_BEEF);
        check_val("rd1_resp", 32'(r), 32'd0);
        check_val("rd1_lat", 32'(lat), 32'd3);
        do_read(32'h8000_0013, d, r, lat);
        check_val("rd_unaligned", d, 32'hDEAD_BEEF);

        // Byte strobes, W ahead of AW, B back-pressure.
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, r, lat);
        do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2, 4, r, lat);
        check_val("strb_resp", 32'(r), 32'd0);
        check_val("strb_lat", 32'(lat), 32'd3);
        do_read(32'h8000_0020, d, r, lat);
        check_val("strb_data", d, 32'h11BB_33DD);
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 0, 0, r, lat);
        check_val("strb0_resp", 32'(r), 32'd0);
        do_read(32'h8000_0020, d, r, lat);
        check_val("strb0_data", d, 32'h11BB_33DD);

        // Decode errors below the base and one word past the end.
        do_read(32'h7FFF_FFFC, d, r, lat);
        check_val("oor_rd_resp", 32'(r), 32'd2);
        check_val("oor_rd_data", d, 32'd0);
        check_val("oor_rd_lat", 32'(lat), 32'd3);
        do_write(32'h8000_3FFC, 32'h0BAD_F00D, 4'hF, 0, 0, r, lat);
        do_write(32'h8000_0000, 32'hC0DE_0000, 4'hF, 0, 0, r, lat);
        do_write(32'h8000_4000, 32'h1234_5678, 4'hF, 0, 0, r, lat);
        check_val("oor_wr_resp", 32'(r), 32'd2);
        do_read(32'h8000_3FFC, d, r, lat);
        check_val("last_word", d, 32'h0BAD_F00D);
        check_val("last_word_resp", 32'(r), 32'd0);
        do_read(32'h8000_0000, d, r, lat);
        check_val("word0_unchanged", d, 32'hC0DE_0000);

        // Read sampling word 5 in the same cycle the write commits to it.
        do_write(32'h8000_0014, 32'h5555_0000, 4'hF, 0, 0, r, lat);
        @(negedge clk);
        awaddr = 32'h8000_0014; wdata = 32'h6666_7777; wstrb = 4'hF;
        araddr = 32'h8000_0014;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        check_val("conc_ready", 32'({arready, awready, wready}), 32'b111);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("conc_rd_lat", 32'(lat), 32'd3);
        check_val("conc_bvalid", 32'(bvalid), 32'd1);
        check_val("conc_old_data", rdata, 32'h5555_0000);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        check_val("conc_released", 32'({rvalid, bvalid}), 32'd0);
        $display("concurrent write/read word 5 done");
        do_read(32'h8000_0014, d, r, lat);
        check_val("conc_new_data", d, 32'h6666_7777);

        // Reset while the write sits in its latency countdown.
        @(negedge clk);
        awaddr = 32'h8000_0014; wdata = 32'h9999_9999; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        seen_b = 1'b0;
        @(negedge clk);
        seen_b = seen_b | bvalid;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_b = seen_b | bvalid;
        end
        check_val("midrst_no_b", 32'(seen_b), 32'd0);
        $display("reset during pending write done");
        do_read(32'h8000_0014, d, r, lat);
        check_val("midrst_unchanged", d, 32'h6666_7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
